// File: rtl/idma_desc64_addr_arbiter.sv
// Round-robin arbiter that shares the desc64 descriptor-address input between NumReq submitters.
// The winning address is registered toward the address FIFO. An outstanding-descriptor count is
// kept per submitter, and each submitter is throttled once it has MaxOutstanding descriptors in
// flight.
module idma_desc64_addr_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_valid_i,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic                        out_valid_o,
    output logic [AddrWidth-1:0]        out_addr_o,
    output logic [IdWidth-1:0]          out_id_o,
    input  logic                        out_ready_i,
    input  logic                        done_valid_i,
    input  logic [IdWidth-1:0]          done_id_i,
    output logic [NumReq-1:0]           busy_o,
    output logic                        done_err_o
);

    logic                 out_valid_q, out_valid_d;
    logic [AddrWidth-1:0] out_addr_q, out_addr_d;
    logic [IdWidth-1:0]   out_id_q, out_id_d;
    logic [IdWidth-1:0]   rr_q, rr_d;
    logic [CntWidth-1:0]  cnt_q [NumReq];
    logic [CntWidth-1:0]  cnt_d [NumReq];
    logic                 done_err_q, done_err_d;

    logic                 load;
    logic [NumReq-1:0]    eligible;
    logic [NumReq-1:0]    grant;
    logic                 grant_valid;
    logic [IdWidth-1:0]   grant_id;
    logic [AddrWidth-1:0] grant_addr;
    logic [NumReq-1:0]    dec;
    int unsigned          scan_idx;

    // The output register can take a new word when empty or when it drains this cycle.
    assign load = !out_valid_q || out_ready_i;

    // A submitter competes only while it is below its in-flight limit.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
        end
    end

    // Round-robin scan starting at rr_q; the first eligible index wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        if (load) begin
            for (int unsigned k = 0; k < NumReq; k++) begin
                scan_idx = 32'(rr_q) + k;
                if (scan_idx >= NumReq) begin
                    scan_idx = scan_idx - NumReq;
                end
                if (!grant_valid && eligible[scan_idx]) begin
                    grant_valid      = 1'b1;
                    grant_id         = IdWidth'(scan_idx);
                    grant[scan_idx]  = 1'b1;
                end
            end
        end
    end

    // Mux out the winning address using constant slices.
    always_comb begin
        grant_addr = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (grant[i]) begin
                grant_addr = req_addr_i[i*AddrWidth +: AddrWidth];
            end
        end
    end

    // Output word, round-robin pointer and error pulse next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_id_d    = out_id_q;
        rr_d        = rr_q;
        if (grant_valid) begin
            out_valid_d = 1'b1;
            out_addr_d  = grant_addr;
            out_id_d    = grant_id;
            if (grant_id == IdWidth'(NumReq - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = grant_id + IdWidth'(1);
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        // A completion that matched no non-zero counter (including out-of-range ids) is an error.
        done_err_d = done_valid_i && (dec == '0);
    end

    // Completion decode: only decrement a counter that is non-zero, so it never wraps.
    always_comb begin
        dec = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            dec[i] = done_valid_i && (done_id_i == IdWidth'(i)) && (cnt_q[i] != '0);
        end
    end

    // Outstanding counters: grant and completion in the same cycle cancel out.
    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end else if (!grant[i] && dec[i]) begin
                cnt_d[i] = cnt_q[i] - CntWidth'(1);
            end
        end
    end

    // State registers with synchronous reset; reset discards any in-flight output word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_id_q    <= '0;
            rr_q        <= '0;
            done_err_q  <= 1'b0;
            for (int unsigned i = 0; i < NumReq; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_id_q    <= out_id_d;
            rr_q        <= rr_d;
            done_err_q  <= done_err_d;
            for (int unsigned i = 0; i < NumReq; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Busy flags straight from the counter registers.
    always_comb begin
        busy_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            busy_o[i] = (cnt_q[i] != '0);
        end
    end

    assign req_ready_o = rst_i ? '0 : grant;
    assign out_valid_o = out_valid_q;
    assign out_addr_o  = out_addr_q;
    assign out_id_o    = out_id_q;
    assign done_err_o  = done_err_q;

endmodule

// File: tb/tb_idma_desc64_addr_arbiter.sv
// Self-checking bench for idma_desc64_addr_arbiter: NumReq=4, MaxOutstanding=2.
// A table of per-cycle vectors checks grants, busy flags and error pulses. A scoreboard queue
// checks every word the FIFO side accepts. A hand-written sequence covers backpressure stability.
module tb_idma_desc64_addr_arbiter;

    localparam int unsigned NumReq = 4;
    localparam int unsigned AW     = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req_valid;
    logic [4*AW-1:0]   req_addr;
    logic [3:0]        req_ready;
    logic              out_valid;
    logic [AW-1:0]     out_addr;
    logic [1:0]        out_id;
    logic              out_ready;
    logic              done_valid;
    logic [1:0]        done_id;
    logic [3:0]        busy;
    logic              done_err;

    idma_desc64_addr_arbiter #(
        .NumReq         (NumReq),
        .AddrWidth      (AW),
        .MaxOutstanding (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_ready_o  (req_ready),
        .out_valid_o  (out_valid),
        .out_addr_o   (out_addr),
        .out_id_o     (out_id),
        .out_ready_i  (out_ready),
        .done_valid_i (done_valid),
        .done_id_i    (done_id),
        .busy_o       (busy),
        .done_err_o   (done_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] valid;
        logic       oready;
        logic       dv;
        logic [1:0] did;
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic [3:0] exp_busy;
        logic       exp_err;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    id;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sb_q[$];
    sb_t         mon_e;
    logic [AW-1:0] addr_arr [4];
    logic [AW-1:0] held_addr;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          gen      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic o, input logic dv,
                       input logic [1:0] did, input logic [3:0] er, input logic eov,
                       input logic [3:0] eb, input logic ee);
        vec_t t;
        t = '{r, v, o, dv, did, er, eov, eb, ee};
        vecs.push_back(t);
    endtask

    // Drive one cycle of inputs with fresh, distinct addresses.
    task automatic drive(input logic r, input logic [3:0] v, input logic o, input logic dv,
                         input logic [1:0] did);
        rst        = r;
        req_valid  = v;
        out_ready  = o;
        done_valid = dv;
        done_id    = did;
        for (int i = 0; i < 4; i++) begin
            addr_arr[i] = {8'hA5, 8'(i), 16'(gen), 32'h0BAD_0000 + 32'(i)};
            req_addr[i*AW +: AW] = addr_arr[i];
        end
        gen++;
    endtask

    // Record the word the bench expects to be granted this cycle.
    task automatic push_expected(input logic [3:0] er);
        sb_t e;
        for (int i = 0; i < 4; i++) begin
            if (er[i]) begin
                e.addr = addr_arr[i];
                e.id   = 2'(i);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each word accepted by the FIFO side must match the oldest expected grant.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got id %0d addr %h expected no word", out_id,
                         out_addr);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb addr", out_addr, mon_e.addr);
                check("sb id", 64'(out_id), 64'(mon_e.id));
            end
        end
    end

    initial begin
        drive(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);

        //   rst valid    ordy dv did   exp_ready ov busy     err
        add(1, 4'b1111, 1, 0, 2'd0, 4'b0000, 0, 4'b0000, 0);  // reset with all valid
        add(1, 4'b1111, 1, 0, 2'd0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b1111, 1, 0, 2'd0, 4'b0001, 1, 4'b0001, 0);  // fairness 0,1,2,3,0
        add(0, 4'b1111, 1, 0, 2'd0, 4'b0010, 1, 4'b0011, 0);
        add(0, 4'b1111, 1, 0, 2'd0, 4'b0100, 1, 4'b0111, 0);
        add(0, 4'b1111, 1, 0, 2'd0, 4'b1000, 1, 4'b1111, 0);
        add(0, 4'b1111, 1, 0, 2'd0, 4'b0001, 1, 4'b1111, 0);
        add(0, 4'b1111, 0, 0, 2'd0, 4'b0000, 1, 4'b1111, 0);  // backpressure: no grant
        add(0, 4'b1111, 1, 0, 2'd0, 4'b0010, 1, 4'b1111, 0);  // ready back: grant same cycle
        add(0, 4'b0000, 1, 1, 2'd0, 4'b0000, 0, 4'b1111, 0);  // drain; completions
        add(0, 4'b0000, 1, 1, 2'd3, 4'b0000, 0, 4'b0111, 0);
        add(0, 4'b0000, 1, 1, 2'd3, 4'b0000, 0, 4'b0111, 1);  // id 3 with count 0 -> error
        add(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 4'b0111, 0);  // error is a single pulse
        add(0, 4'b0100, 1, 0, 2'd0, 4'b0100, 1, 4'b0111, 0);
        add(1, 4'b1111, 0, 0, 2'd0, 4'b0000, 0, 4'b0000, 0);  // mid-op reset
        add(0, 4'b0110, 1, 0, 2'd0, 4'b0010, 1, 4'b0010, 0);  // lowest valid after reset
        add(0, 4'b0010, 1, 0, 2'd0, 4'b0010, 1, 4'b0010, 0);  // second grant to req 1
        add(0, 4'b0010, 1, 0, 2'd0, 4'b0000, 0, 4'b0010, 0);  // throttled at 2
        add(0, 4'b0010, 1, 1, 2'd1, 4'b0000, 0, 4'b0010, 0);  // completion -> count 1
        add(0, 4'b0010, 1, 0, 2'd0, 4'b0010, 1, 4'b0010, 0);  // third grant
        add(0, 4'b0010, 1, 1, 2'd1, 4'b0000, 0, 4'b0010, 0);  // count 2 -> 1
        add(0, 4'b0010, 1, 1, 2'd1, 4'b0010, 1, 4'b0010, 0);  // grant + done: stays 1
        add(0, 4'b0010, 1, 0, 2'd0, 4'b0010, 1, 4'b0010, 0);  // count 2
        add(0, 4'b0010, 1, 0, 2'd0, 4'b0000, 0, 4'b0010, 0);  // throttled again
        add(0, 4'b0000, 1, 1, 2'd1, 4'b0000, 0, 4'b0010, 0);
        add(0, 4'b0000, 1, 1, 2'd1, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0000, 1, 1, 2'd1, 4'b0000, 0, 4'b0000, 1);  // underflow attempt -> error

        #2;
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].valid, vecs[k].oready, vecs[k].dv, vecs[k].did);
            #1;
            check($sformatf("v%0d req_ready", k), 64'(req_ready), 64'(vecs[k].exp_ready));
            if (vecs[k].rst) begin
                sb_q.delete();
            end else begin
                push_expected(vecs[k].exp_ready);
            end
            step();
            check($sformatf("v%0d out_valid", k), 64'(out_valid), 64'(vecs[k].exp_ov));
            check($sformatf("v%0d busy", k), 64'(busy), 64'(vecs[k].exp_busy));
            check($sformatf("v%0d done_err", k), 64'(done_err), 64'(vecs[k].exp_err));
            if (k == 1) begin
                check("reset out_addr", out_addr, 64'd0);
                check("reset out_id", 64'(out_id), 64'd0);
            end
        end

        // Hand sequence: word held stable under backpressure, released with same-cycle grant.
        drive(1'b0, 4'b1000, 1'b0, 1'b0, 2'd0);
        #1;
        check("hs grant3", 64'(req_ready), 64'b1000);
        push_expected(4'b1000);
        held_addr = addr_arr[3];
        step();
        check("hs latency valid", 64'(out_valid), 64'd1);
        check("hs latency addr", out_addr, held_addr);
        check("hs latency id", 64'(out_id), 64'd3);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
            #1;
            check($sformatf("hs stall%0d ready", c), 64'(req_ready), 64'd0);
            step();
            check($sformatf("hs stall%0d addr", c), out_addr, held_addr);
            check($sformatf("hs stall%0d valid", c), 64'(out_valid), 64'd1);
        end
        drive(1'b0, 4'b0001, 1'b1, 1'b0, 2'd0);
        #1;
        check("hs release ready", 64'(req_ready), 64'b0001);
        push_expected(4'b0001);
        held_addr = addr_arr[0];
        step();
        check("hs next addr", out_addr, held_addr);
        check("hs next id", 64'(out_id), 64'd0);
        drive(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
        step();
        check("hs drained valid", 64'(out_valid), 64'd0);
        check("sb drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
